// File: rtl/pc_fetch.sv
// Instruction fetch stage: one PC, one outstanding bus transaction, prioritised redirects.
// Optional PC_ALIGN_CHECK_EN raises adelF on a misaligned PC instead of issuing the fetch.
module pc_fetch (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        exception,
    input  logic [31:0] pcexception,
    input  logic        branch_taken,
    input  logic [31:0] pcbranchD,
    input  logic        jr,
    input  logic [31:0] pcjrD,
    input  logic        jump,
    input  logic [31:0] pcjumpD,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        instr_valid,
    output logic [31:0] instrF,
    output logic [31:0] pcF,
    output logic [31:0] pcplus4F,
    output logic        adelF
);

    localparam logic [31:0] BOOT_PC = 32'hBFC0_0000;
    localparam int          NSRC    = 4;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] pcf_reg, pcf_next;
    logic        valid_reg, valid_next;

    logic            misalign;
    logic            accept;
    logic            redirect;
    logic [31:0]     redirect_pc;
    logic [NSRC-1:0] src_req;
    logic [NSRC-1:0] src_win;
    logic [31:0]     src_pc   [NSRC];
    logic [31:0]     src_term [NSRC];

    // Index 0 is the highest priority; only exception bypasses the stall gate.
    assign src_req   = {jump & ~stall, jr & ~stall, branch_taken & ~stall, exception};
    assign src_pc[0] = pcexception;
    assign src_pc[1] = pcbranchD;
    assign src_pc[2] = pcjrD;
    assign src_pc[3] = pcjumpD;

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_prio
            if (gi == 0) begin : g_top
                assign src_win[gi] = src_req[gi];
            end else begin : g_low
                assign src_win[gi] = src_req[gi] & ~(|src_req[gi-1:0]);
            end
            assign src_term[gi] = src_win[gi] ? src_pc[gi] : 32'd0;
        end
    endgenerate

    always_comb begin
        redirect_pc = 32'd0;
        for (int i = 0; i < NSRC; i++) begin
            redirect_pc = redirect_pc | src_term[i];
        end
    end

    assign redirect = |src_req;
    assign accept   = inst_req & inst_addr_ok;

`ifdef PC_ALIGN_CHECK_EN
    logic adel_reg;

    assign misalign  = (state_reg == ST_REQ) && (pc_reg[1:0] != 2'b00);
    assign inst_addr = pc_reg;
    assign adelF     = adel_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            adel_reg <= 1'b0;
        end else if (state_reg == ST_REQ && !redirect && misalign) begin
            adel_reg <= 1'b1;
        end else if (state_reg == ST_HOLD && (redirect || !stall)) begin
            adel_reg <= 1'b0;
        end
    end
`else
    assign misalign  = 1'b0;
    assign inst_addr = {pc_reg[31:2], 2'b00};
    assign adelF     = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_REQ;
            pc_reg    <= BOOT_PC;
            instr_reg <= 32'd0;
            pcf_reg   <= BOOT_PC;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            pcf_reg   <= pcf_next;
            valid_reg <= valid_next;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        instr_next = instr_reg;
        pcf_next   = pcf_reg;
        valid_next = valid_reg;
        case (state_reg)
            ST_REQ: begin
                if (redirect) begin
                    pc_next    = redirect_pc;
                    valid_next = 1'b0;
                    state_next = accept ? ST_DRAIN : ST_REQ;
                end else if (misalign) begin
                    instr_next = 32'd0;
                    pcf_next   = pc_reg;
                    valid_next = 1'b1;
                    state_next = ST_HOLD;
                end else if (accept) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    pc_next    = redirect_pc;
                    valid_next = 1'b0;
                    state_next = inst_data_ok ? ST_REQ : ST_DRAIN;
                end else if (inst_data_ok) begin
                    instr_next = inst_rdata;
                    pcf_next   = pc_reg;
                    valid_next = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_next    = redirect_pc;
                    valid_next = 1'b0;
                    state_next = ST_REQ;
                end else if (!stall) begin
                    pc_next    = pc_reg + 32'd4;
                    valid_next = 1'b0;
                    state_next = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (redirect) begin
                    pc_next    = redirect_pc;
                    valid_next = 1'b0;
                end
                // The stale response retires the only outstanding request, even when
                // a fresh redirect lands in the same cycle.
                if (inst_data_ok) begin
                    state_next = ST_REQ;
                end
            end
            default: begin
                state_next = ST_REQ;
            end
        endcase
    end

    // Outputs
    always_comb begin
        inst_req    = (state_reg == ST_REQ) && !misalign;
        instr_valid = valid_reg;
        instrF      = instr_reg;
        pcF         = pcf_reg;
        pcplus4F    = pcf_reg + 32'd4;
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: architectural PC-stream model plus a random bus responder.
// Directed prologue covers boot, stall hold, stale drain, priority, misalignment and reset.
module tb_pc_fetch;

    localparam logic [31:0] BOOT = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        reset, stall, exception, branch_taken, jr, jump;
    logic [31:0] pcexception, pcbranchD, pcjrD, pcjumpD;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic        instr_valid, adelF;
    logic [31:0] instrF, pcF, pcplus4F;

    always #5 clk = ~clk;

    pc_fetch dut (
        .clk(clk), .reset(reset), .stall(stall),
        .exception(exception), .pcexception(pcexception),
        .branch_taken(branch_taken), .pcbranchD(pcbranchD),
        .jr(jr), .pcjrD(pcjrD), .jump(jump), .pcjumpD(pcjumpD),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .instr_valid(instr_valid), .instrF(instrF), .pcF(pcF),
        .pcplus4F(pcplus4F), .adelF(adelF)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic exp_t make_exp(input logic [31:0] pc);
        exp_t e;
        e.pc = pc;
`ifdef PC_ALIGN_CHECK_EN
        e.adel  = (pc[1:0] != 2'b00);
        e.instr = e.adel ? 32'd0 : mem_word({pc[31:2], 2'b00});
`else
        e.adel  = 1'b0;
        e.instr = mem_word({pc[31:2], 2'b00});
`endif
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference model: the next fetch the core is architecturally owed.
    task automatic tick();
        logic        applied;
        logic [31:0] tgt;
        if (reset) begin
            model_pc = BOOT;
            exp_q.delete();
            exp_q.push_back(make_exp(BOOT));
        end else begin
            applied = exception || (!stall && (branch_taken || jr || jump));
            tgt = exception ? pcexception : branch_taken ? pcbranchD : jr ? pcjrD : pcjumpD;
            if (applied) begin
                model_pc = tgt;
                exp_q.delete();
                exp_q.push_back(make_exp(tgt));
            end else if (instr_valid && !stall) begin
                model_pc = model_pc + 32'd4;
                exp_q.delete();
                exp_q.push_back(make_exp(model_pc));
            end
        end
        @(negedge clk);
        #1;
    endtask

    // Monitor
    logic        prev_valid = 1'b0;
    logic [31:0] held_pc, held_instr;
    exp_t        got;

    always @(negedge clk) begin
        if (instr_valid === 1'b1 && !prev_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_fetch actual pc=%h required none", pcF);
            end else begin
                got = exp_q.pop_front();
                check("pcF", pcF, got.pc);
                check("instrF", instrF, got.instr);
                check("pcplus4F", pcplus4F, got.pc + 32'd4);
                check("adelF", {31'd0, adelF}, {31'd0, got.adel});
                $display("fetch pc=%h instr=%h adel=%0d", pcF, instrF, adelF);
            end
            held_pc    = pcF;
            held_instr = instrF;
        end else if (instr_valid === 1'b1 && prev_valid) begin
            check("hold_pcF", pcF, held_pc);
            check("hold_instrF", instrF, held_instr);
        end
        if (inst_req === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req actual addr=%h required none", inst_addr);
            end else begin
                check("inst_addr", inst_addr, {exp_q[0].pc[31:2], 2'b00});
            end
        end
        prev_valid = (instr_valid === 1'b1);
    end

    task automatic clear_in();
        stall = 0; exception = 0; branch_taken = 0; jr = 0; jump = 0;
        inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = 32'd0;
    endtask

    logic        pending;
    logic [31:0] pend_addr;
    int          delay;
    int          idle;

    initial begin
        clear_in();
        reset = 1;
        pcexception = 0; pcbranchD = 0; pcjrD = 0; pcjumpD = 0;
        model_pc = BOOT;
        tick();
        tick();
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instrF", instrF, 32'd0);
        check("rst_pcF", pcF, BOOT);
        check("rst_adelF", {31'd0, adelF}, 32'd0);
        check("rst_inst_req", {31'd0, inst_req}, 32'd1);

        // Boot fetch: accept in cycle 1, data in cycle 2
        reset = 0;
        inst_addr_ok = 1; tick(); clear_in();
        check("wait_no_req", {31'd0, inst_req}, 32'd0);
        inst_data_ok = 1; inst_rdata = mem_word(BOOT); tick(); clear_in();
        check("boot_valid", {31'd0, instr_valid}, 32'd1);
        check("boot_pcplus4", pcplus4F, 32'hBFC0_0004);

        // Stall hold
        stall = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_req", {31'd0, inst_req}, 32'd0);
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
        end
        stall = 0; tick();
        check("seq_addr", inst_addr, 32'hBFC0_0004);

        // Branch in WAIT, stale response must be dropped
        inst_addr_ok = 1; tick(); clear_in();
        branch_taken = 1; pcbranchD = 32'hBFC0_0100; tick(); clear_in();
        check("drain_no_req", {31'd0, inst_req}, 32'd0);
        inst_data_ok = 1; inst_rdata = 32'hDEAD_BEEF; tick(); clear_in();
        check("drain_valid", {31'd0, instr_valid}, 32'd0);
        check("branch_addr", inst_addr, 32'hBFC0_0100);
        inst_addr_ok = 1; tick(); clear_in();
        inst_data_ok = 1; inst_rdata = mem_word(32'hBFC0_0100); tick(); clear_in();
        check("branch_instr", instrF, mem_word(32'hBFC0_0100));

        // Exception beats jump, even under stall
        exception = 1; pcexception = 32'hBFC0_0380;
        jump = 1; pcjumpD = 32'h8000_1000; stall = 1;
        tick(); clear_in();
        check("exc_addr", inst_addr, 32'hBFC0_0380);
        check("exc_valid", {31'd0, instr_valid}, 32'd0);
        inst_addr_ok = 1; tick(); clear_in();
        inst_data_ok = 1; inst_rdata = mem_word(32'hBFC0_0380); tick(); clear_in();

        // Misaligned jr target
        jr = 1; pcjrD = 32'h8000_0002; tick(); clear_in();
`ifdef PC_ALIGN_CHECK_EN
        check("mis_no_req", {31'd0, inst_req}, 32'd0);
        tick();
        check("mis_adel", {31'd0, adelF}, 32'd1);
        check("mis_pcF", pcF, 32'h8000_0002);
`else
        check("mis_req", {31'd0, inst_req}, 32'd1);
        check("mis_addr", inst_addr, 32'h8000_0000);
        inst_addr_ok = 1; tick(); clear_in();
        inst_data_ok = 1; inst_rdata = mem_word(32'h8000_0000); tick(); clear_in();
        check("mis_pcF", pcF, 32'h8000_0002);
`endif

        // Reset while a request is outstanding
        branch_taken = 1; pcbranchD = 32'h8000_0100; tick(); clear_in();
        inst_addr_ok = 1; tick(); clear_in();
        reset = 1; tick(); reset = 0;
        check("rst_wait_req", {31'd0, inst_req}, 32'd1);
        check("rst_wait_addr", inst_addr, BOOT);
        check("rst_wait_valid", {31'd0, instr_valid}, 32'd0);

        // Random phase
        pending = 0; pend_addr = 0; delay = 0; idle = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            clear_in();
            reset = ($urandom_range(0, 299) == 0);
            stall = ($urandom_range(0, 2) == 0);
            exception = ($urandom_range(0, 39) == 0);
            branch_taken = ($urandom_range(0, 14) == 0);
            jr = ($urandom_range(0, 24) == 0);
            jump = ($urandom_range(0, 24) == 0);
            pcexception = $urandom & 32'hFFFF_FFFC;
            pcbranchD = $urandom & 32'hFFFF_FFFC;
            pcjrD = $urandom & 32'hFFFF_FFFC;
            pcjumpD = $urandom & 32'hFFFF_FFFC;
            inst_rdata = $urandom;
            if (reset) begin
                pending = 0;
            end else if (pending) begin
                if (delay == 0) begin
                    inst_data_ok = 1;
                    inst_rdata = mem_word(pend_addr);
                    pending = 0;
                end else begin
                    delay--;
                end
            end else begin
                inst_addr_ok = ($urandom_range(0, 3) != 0);
                if (inst_addr_ok && inst_req) begin
                    pending = 1;
                    pend_addr = inst_addr;
                    delay = $urandom_range(0, 3);
                end else if ($urandom_range(0, 7) == 0) begin
                    inst_data_ok = 1;
                end
            end
            tick();
            if (instr_valid || reset) idle = 0;
            else idle++;
            if (idle > 200) begin
                checks++;
                errors++;
                $display("FAIL watchdog actual idle=%0d required <=200", idle);
                break;
            end
        end
        clear_in();
        reset = 0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
